// File: rtl/sar_search_pkg.sv
// Shared constants for the sar_search8 successive-approximation controller.
package sar_search_pkg;

  localparam int SAR_WIDTH = 8;
  localparam int SAR_IDX_W = $clog2(SAR_WIDTH);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_TRIAL = 1'b1;

endpackage

// File: rtl/comparator8_bit.sv
// Combinational 8-bit unsigned magnitude comparator; the target device the search controller probes.
module comparator8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       lt,
  output logic       eq,
  output logic       gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/sar_search8_flag_check.sv
// One-hot sanity check on the comparator result flags {lt, eq, gt}.
module cmp_flag_check (
  input  logic lt,
  input  logic eq,
  input  logic gt,
  output logic flag_ok
);

  // Odd parity rules out 0 and 2 set; the AND term rules out all three set.
  assign flag_ok = (lt ^ eq ^ gt) & ~(lt & eq & gt);

endmodule

// File: rtl/sar_search8.sv
// Successive-approximation search controller: binary-searches the comparator's a operand, MSB first.
// Optional build macro: SAR_EARLY_EXIT_EN (finish as soon as the comparator reports equality).
module sar_search8
  import sar_search_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] cmp_b,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] cmp_b_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] result_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             err_reg;

  logic             flag_ok;
  logic             keep;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] bit_mask;

  cmp_flag_check u_flag_check (
    .lt      (cmp_lt),
    .eq      (cmp_eq),
    .gt      (cmp_gt),
    .flag_ok (flag_ok)
  );

  assign keep     = cmp_gt | cmp_eq;
  assign acc_next = keep ? cmp_b_reg : acc_reg;
  // Next bit to try; only meaningful while idx_reg > 0.
  assign bit_mask = LSB_ONLY << (idx_reg - IDX_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cmp_b_reg  <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      idx_reg    <= IDX_W'(WIDTH-1);
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // A start coinciding with the done pulse is deliberately dropped.
          if (start && !done_reg) begin
            acc_reg   <= '0;
            idx_reg   <= IDX_W'(WIDTH-1);
            cmp_b_reg <= MSB_ONLY;
            busy_reg  <= 1'b1;
            err_reg   <= 1'b0;
            state_reg <= ST_TRIAL;
          end
        end
        default: begin
          if (!flag_ok) begin
            result_reg <= acc_reg;
            err_reg    <= 1'b1;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= ST_IDLE;
          end
`ifdef SAR_EARLY_EXIT_EN
          else if (cmp_eq) begin
            result_reg <= cmp_b_reg;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= ST_IDLE;
          end
`endif
          else if (idx_reg == '0) begin
            result_reg <= acc_next;
            done_reg   <= 1'b1;
            busy_reg   <= 1'b0;
            state_reg  <= ST_IDLE;
          end else begin
            acc_reg   <= acc_next;
            cmp_b_reg <= acc_next | bit_mask;
            idx_reg   <= idx_reg - IDX_W'(1);
          end
        end
      endcase
    end
  end

  assign cmp_b  = cmp_b_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;
  assign err    = err_reg;

endmodule
